// File: rtl/wb_loader_if.sv
// Host byte-stream link (rx/tx) and Wishbone master bus used by wb_loader.
// The loader takes the master modport; the host/bus side takes the slave modport.
interface wb_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_strobe_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  modport master (
    input  rx_data, rx_valid, tx_ready, wb_data_i, wb_ack_i,
    output rx_ready, tx_data, tx_valid,
    output wb_addr_o, wb_data_o, wb_we_o, wb_cyc_o, wb_strobe_o
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wb_data_i, wb_ack_i,
    input  rx_ready, tx_data, tx_valid,
    input  wb_addr_o, wb_data_o, wb_we_o, wb_cyc_o, wb_strobe_o
  );
endinterface

// File: rtl/wb_loader.sv
// Byte-command to Wishbone bridge: 'W'/'R' commands become single bus cycles with a byte response.
// Optional macro WB_LOADER_AUTOINC_EN adds the 'I' command (write to previous address + 4).
module wb_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  wb_loader_if.master bus,
  output logic        busy,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  localparam logic [7:0]  CMD_W   = 8'h57;
  localparam logic [7:0]  CMD_R   = 8'h52;
  localparam logic [7:0]  RSP_K   = 8'h4B;
  localparam logic [7:0]  RSP_UNK = 8'h3F;
  localparam logic [7:0]  RSP_TO  = 8'hEE;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
`ifdef WB_LOADER_AUTOINC_EN
  localparam logic [7:0]  CMD_I   = 8'h49;
`endif

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;
  logic [2:0]  len_q, len_d;
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        rx_rdy, rx_fire, tx_fire;

  // rx_ready is gated by reset_n so the host sees "not ready" for the whole reset pulse.
  assign rx_rdy  = reset_n && ((state_q == IDLE) || (state_q == ADDR) || (state_q == DATA));
  assign rx_fire = bus.rx_valid && rx_rdy;
  assign tx_fire = (state_q == RESP) && bus.tx_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          case (bus.rx_data)
            CMD_W: begin
              we_d    = 1'b1;
              state_d = ADDR;
            end
            CMD_R: begin
              we_d    = 1'b0;
              state_d = ADDR;
            end
`ifdef WB_LOADER_AUTOINC_EN
            CMD_I: begin
              we_d    = 1'b1;
              addr_d  = addr_q + 32'd4;
              state_d = DATA;
            end
`endif
            default: begin
              resp_d  = {24'h0, RSP_UNK};
              len_d   = 3'd1;
              state_d = RESP;
            end
          endcase
        end
      end

      // Bytes arrive LSB first, so each one is shifted in from the top.
      ADDR: begin
        if (rx_fire) begin
          addr_d = {bus.rx_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = we_q ? DATA : BUS;
        end
      end

      DATA: begin
        if (rx_fire) begin
          wdata_d = {bus.rx_data, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = BUS;
        end
      end

      // Ack wins over a timeout landing in the same cycle.
      BUS: begin
        if (bus.wb_ack_i) begin
          resp_d  = we_q ? {24'h0, RSP_K} : bus.wb_data_i;
          len_d   = we_q ? 3'd1 : 3'd4;
          state_d = RESP;
        end else if (tmo_q == TO_LAST) begin
          err_d   = 1'b1;
          resp_d  = {24'h0, RSP_TO};
          len_d   = 3'd1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      RESP: begin
        if (tx_fire) begin
          resp_d = resp_q >> 8;
          len_d  = len_q - 3'd1;
          if (len_q == 3'd1) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    if ((state_d == BUS) && (state_q != BUS)) tmo_d = '0;
  end

  assign bus.rx_ready    = rx_rdy;
  assign bus.tx_valid    = (state_q == RESP);
  assign bus.tx_data     = resp_q[7:0];
  assign bus.wb_cyc_o    = (state_q == BUS);
  assign bus.wb_strobe_o = (state_q == BUS);
  assign bus.wb_we_o     = (state_q == BUS) && we_q;
  assign bus.wb_addr_o   = addr_q;
  assign bus.wb_data_o   = wdata_q;
  assign busy            = (state_q != IDLE);
  assign error           = err_q;
endmodule

// File: doc/wb_loader.md
WB_LOADER -- requirements
Module: wb_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for wb_ack_i before abort (range 1..65535).
REQ-002 SHALL have port clock, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rx_data, input, 8 bits: command stream byte from host.
REQ-005 SHALL have port rx_valid, input, 1 bit: rx_data valid.
REQ-006 SHALL have port rx_ready, output, 1 bit: loader accepts byte; transfer occurs when rx_valid && rx_ready.
REQ-007 SHALL have port tx_data, output, 8 bits: response byte to host.
REQ-008 SHALL have port tx_valid, output, 1 bit: tx_data valid.
REQ-009 SHALL have port tx_ready, input, 1 bit: host accepts byte; transfer occurs when tx_valid && tx_ready.
REQ-010 SHALL have ports wb_addr_o[31:0], wb_data_o[31:0], wb_we_o, wb_cyc_o and wb_strobe_o, all outputs: Wishbone master request into the wb_system backdoor.
REQ-011 SHALL have ports wb_data_i[31:0] and wb_ack_i, both inputs: Wishbone response.
REQ-012 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-013 SHALL have port error, output, 1 bit: sticky flag, set on bus timeout.

Function
REQ-014 SHALL implement the states IDLE, ADDR, DATA, BUS, RESP.
REQ-015 IDLE: rx_ready=1; on accepted byte 0x57 ('W') go to ADDR with write flag set; on 0x52 ('R') go to ADDR with write flag clear; on any other byte load 0x3F into the response and go to RESP with a length of 1.
REQ-016 ADDR: accept 4 bytes, LSB first, into the address register; after the 4th byte go to DATA if writing, otherwise go to BUS.
REQ-017 DATA: accept 4 bytes, LSB first, into the write-data register; after the 4th byte go to BUS.
REQ-018 rx_ready SHALL be 1 only in IDLE, ADDR and DATA; a byte counter (2 bits) SHALL wrap to 0 on each state change.
REQ-019 BUS: assert wb_cyc_o=wb_strobe_o=1 and wb_we_o equal to the write flag; hold wb_addr_o and wb_data_o stable until ack or abort.
REQ-020 On wb_ack_i in BUS: deassert cyc/strobe on the next edge. A write SHALL load response 0x4B ('K') with length 1. A read SHALL capture wb_data_i and set length 4. Then go to RESP.
REQ-021 A timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack; when it reaches TIMEOUT, drop cyc/strobe, set error, load response 0xEE with length 1, and go to RESP.
REQ-022 An ack and the timeout reaching TIMEOUT in the same cycle SHALL be treated as an ack.
REQ-023 wb_ack_i outside BUS SHALL be ignored.
REQ-024 RESP: tx_valid=1; emit the response bytes LSB first; advance only on a tx handshake; after the last byte return to IDLE. tx_data SHALL hold stable while tx_ready=0.
REQ-025 At most one Wishbone transaction SHALL be outstanding; commands are strictly serialized.
REQ-026 Latency: the strobe SHALL assert on the cycle after the last command byte is accepted.

Reset
REQ-027 On reset_n=0, asynchronously: state=IDLE, all registers and counters 0, rx_ready=0 while reset_n is low, tx_valid=0, wb_cyc_o=wb_strobe_o=wb_we_o=0, wb_addr_o=wb_data_o=0, busy=0, error=0.
REQ-028 Reset asserted mid-transaction SHALL drop cyc/strobe immediately and discard any partial command or response.
REQ-029 error SHALL be cleared only by reset.

Configuration
REQ-030 Macro WB_LOADER_AUTOINC_EN: when defined, IDLE SHALL also accept 0x49 ('I'), which skips ADDR, increments the address register by 4 (wrapping modulo 2^32), goes to DATA, and then writes.
REQ-031 When WB_LOADER_AUTOINC_EN is defined, 'W' and 'R' SHALL be unchanged.
REQ-032 Without WB_LOADER_AUTOINC_EN, 0x49 SHALL be treated as an unknown command and return 0x3F.

Verification
REQ-033 Bytes 57 00 00 00 00 78 56 34 12 with ack after 2 cycles -> one write to addr 0x0 with data 0x12345678, we=1, then tx 0x4B.
REQ-034 Bytes 52 04 00 01 00 with wb_data_i=0xA5A5000F and ack after 1 cycle -> read of addr 0x00010004, we=0, then tx 0F 00 A5 A5.
REQ-035 Read with ack never asserted and TIMEOUT=255 -> cyc drops after 255 cycles, error=1, tx 0xEE; the next 'R' command still completes normally.
REQ-036 Byte 0x00 -> tx 0x3F and no Wishbone activity; tx_ready held low for 10 cycles -> tx_data stable and rx_ready=0 throughout.
REQ-037 reset_n pulsed low during BUS -> cyc/strobe drop in the same cycle and busy=0; the next full 'W' command succeeds.
REQ-038 With WB_LOADER_AUTOINC_EN: 'W' to 0xFFFFFFFC, then 49 01 00 00 00 -> second write goes to addr 0x0 with data 0x1; without the macro, 0x49 returns 0x3F.
